// File: rtl/dkong_video_timing_if.sv
// Raster-timing bundle: CPU controls and clock enable in, counters and blank/sync/NMI flags out.
// master = timing generator, slave = tile stage / CPU side.
interface dkong_video_timing_if;
  logic       CLK_EN;
  logic       I_FLIP;
  logic       I_GFX_BANK;
  logic       I_NMI_ACK;
  logic [9:0] O_H_CNT;
  logic [7:0] O_V_CNT;
  logic [7:0] O_VF_CNT;
  logic       O_FLIP;
  logic       O_4H_Q0;
  logic       O_HBLK;
  logic       O_VBLK;
  logic       O_CMPBLK;
  logic       O_HSYNCn;
  logic       O_VSYNCn;
  logic       O_NMI_REQ;

  modport master (
    input  CLK_EN, I_FLIP, I_GFX_BANK, I_NMI_ACK,
    output O_H_CNT, O_V_CNT, O_VF_CNT, O_FLIP, O_4H_Q0, O_HBLK, O_VBLK, O_CMPBLK,
           O_HSYNCn, O_VSYNCn, O_NMI_REQ
  );

  modport slave (
    output CLK_EN, I_FLIP, I_GFX_BANK, I_NMI_ACK,
    input  O_H_CNT, O_V_CNT, O_VF_CNT, O_FLIP, O_4H_Q0, O_HBLK, O_VBLK, O_CMPBLK,
           O_HSYNCn, O_VSYNCn, O_NMI_REQ
  );
endinterface

// File: rtl/dkong_video_timing.sv
// Donkey Kong raster timing: H/V counters, blank and sync flags, frame-latched flip,
// line-latched tile bank and the vblank NMI request.
module dkong_video_timing #(
  parameter logic [9:0] H_START    = 10'h100,
  parameter logic [9:0] H_SYNC_ST  = 10'h140,
  parameter logic [9:0] H_SYNC_END = 10'h180,
  parameter logic [8:0] V_START    = 9'h0F8,
  parameter logic [8:0] V_ACT_ST   = 9'h110,
  parameter logic [8:0] V_ACT_END  = 9'h1F0,
  parameter logic [8:0] V_SYNC_ST  = 9'h1F8
) (
  input logic                  CLK_24M,
  input logic                  I_RST,
  dkong_video_timing_if.master bus
);

  typedef enum logic {StIdle, StPend} nmi_state_e;

  function automatic logic in_hsync(input logic [9:0] h);
    return (h >= H_SYNC_ST) && (h < H_SYNC_END);
  endfunction

  function automatic logic in_active(input logic [8:0] v);
    return (v >= V_ACT_ST) && (v < V_ACT_END);
  endfunction

  function automatic logic in_vsync(input logic [8:0] v);
    return v >= V_SYNC_ST;
  endfunction

  logic [9:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic       flip_q, bank_q;
  logic       hblk_q, vblk_q, hsync_n_q, vsync_n_q;
  logic       line_end, frame_start, nmi_set;
  nmi_state_e nmi_q, nmi_d;

  always_comb begin
    line_end = (h_q == 10'h3FF);
    h_d      = line_end ? H_START : h_q + 10'd1;
    v_d      = v_q;
    if (line_end) begin
      v_d = (v_q == 9'h1FF) ? V_START : v_q + 9'd1;
    end
    frame_start = line_end && (v_d == V_START);
    nmi_set     = bus.CLK_EN && line_end && (v_d == V_ACT_END);
  end

  // Flags are decoded from the next count so they land on the same edge as the counters.
  always_ff @(posedge CLK_24M or posedge I_RST) begin
    if (I_RST) begin
      h_q       <= H_START;
      v_q       <= V_START;
      flip_q    <= 1'b0;
      bank_q    <= 1'b0;
      hblk_q    <= ~H_START[9];
      vblk_q    <= ~in_active(V_START);
      hsync_n_q <= ~in_hsync(H_START);
      vsync_n_q <= ~in_vsync(V_START);
    end else if (bus.CLK_EN) begin
      h_q       <= h_d;
      v_q       <= v_d;
      hblk_q    <= ~h_d[9];
      vblk_q    <= ~in_active(v_d);
      hsync_n_q <= ~in_hsync(h_d);
      vsync_n_q <= ~in_vsync(v_d);
      if (line_end) begin
        bank_q <= bus.I_GFX_BANK;
      end
      if (frame_start) begin
        flip_q <= bus.I_FLIP;
      end
    end
  end

  // Ack is honoured every clock; a coincident set wins.
  always_comb begin
    nmi_d = nmi_q;
    unique case (nmi_q)
      StIdle:  if (nmi_set) nmi_d = StPend;
      StPend:  if (bus.I_NMI_ACK && !nmi_set) nmi_d = StIdle;
      default: nmi_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_24M or posedge I_RST) begin
    if (I_RST) begin
      nmi_q <= StIdle;
    end else begin
      nmi_q <= nmi_d;
    end
  end

  assign bus.O_H_CNT   = h_q;
  assign bus.O_V_CNT   = v_q[7:0];
  assign bus.O_VF_CNT  = v_q[7:0] ^ {8{flip_q}};
  assign bus.O_FLIP    = flip_q;
  assign bus.O_4H_Q0   = bank_q;
  assign bus.O_HBLK    = hblk_q;
  assign bus.O_VBLK    = vblk_q;
  assign bus.O_CMPBLK  = hblk_q | vblk_q;
  assign bus.O_HSYNCn  = hsync_n_q;
  assign bus.O_VSYNCn  = vsync_n_q;
  assign bus.O_NMI_REQ = (nmi_q == StPend);

endmodule

// File: tb/tb_dkong_video_timing.sv
// Bench for dkong_video_timing: full-size instance A plus a short-line instance B so a whole
// frame fits in a short run; both are checked against a position-arithmetic reference model.
module tb_dkong_video_timing;

  localparam int LEN_A = 768;
  localparam int LEN_B = 64;
  localparam int LINES = 264;
  localparam logic [33:0] RST_A = {10'h100, 8'hF8, 8'hF8, 1'b0, 1'b0,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, flip_in, gfx, ack;

  dkong_video_timing_if bus_a ();
  dkong_video_timing_if bus_b ();

  assign bus_a.CLK_EN     = en;
  assign bus_a.I_FLIP     = flip_in;
  assign bus_a.I_GFX_BANK = gfx;
  assign bus_a.I_NMI_ACK  = ack;
  assign bus_b.CLK_EN     = en;
  assign bus_b.I_FLIP     = flip_in;
  assign bus_b.I_GFX_BANK = gfx;
  assign bus_b.I_NMI_ACK  = ack;

  dkong_video_timing u_a (
    .CLK_24M (clk),
    .I_RST   (rst),
    .bus     (bus_a)
  );

  dkong_video_timing #(
    .H_START    (10'h3C0),
    .H_SYNC_ST  (10'h3D0),
    .H_SYNC_END (10'h3E0)
  ) u_b (
    .CLK_24M (clk),
    .I_RST   (rst),
    .bus     (bus_b)
  );

  wire [33:0] obs_a = {bus_a.O_H_CNT, bus_a.O_V_CNT, bus_a.O_VF_CNT, bus_a.O_FLIP,
                       bus_a.O_4H_Q0, bus_a.O_HBLK, bus_a.O_VBLK, bus_a.O_CMPBLK,
                       bus_a.O_HSYNCn, bus_a.O_VSYNCn, bus_a.O_NMI_REQ};
  wire [33:0] obs_b = {bus_b.O_H_CNT, bus_b.O_V_CNT, bus_b.O_VF_CNT, bus_b.O_FLIP,
                       bus_b.O_4H_Q0, bus_b.O_HBLK, bus_b.O_VBLK, bus_b.O_CMPBLK,
                       bus_b.O_HSYNCn, bus_b.O_VSYNCn, bus_b.O_NMI_REQ};

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: ticks since reset per instance; everything else follows from position arithmetic.
  int   t [2];
  logic m_flip [2];
  logic m_bank [2];
  logic m_nmi [2];

  int a_ticks, a_hs_low, b_lines, b_act, b_vs;
  logic a_prev_hs;

  function automatic int len_of(input int i);
    return (i == 0) ? LEN_A : LEN_B;
  endfunction

  function automatic int model_h(input int i);
    return ((i == 0) ? 256 : 960) + t[i] % len_of(i);
  endfunction

  function automatic int model_v(input int i);
    return 248 + (t[i] / len_of(i)) % LINES;
  endfunction

  function automatic logic [33:0] model_vec(input int i);
    int h, v, ss, se;
    logic [9:0] hh;
    logic [7:0] vv;
    logic hb, vb, hs, vs;
    h  = model_h(i);
    v  = model_v(i);
    ss = (i == 0) ? 320 : 976;
    se = (i == 0) ? 384 : 992;
    hh = 10'(h);
    vv = 8'(v);
    hb = (h < 512);
    vb = !((v >= 272) && (v < 496));
    hs = !((h >= ss) && (h < se));
    vs = !(v >= 504);
    return {hh, vv, vv ^ {8{m_flip[i]}}, m_flip[i], m_bank[i], hb, vb, hb | vb, hs, vs,
            m_nmi[i]};
  endfunction

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; m_flip[i] = 1'b0; m_bank[i] = 1'b0; m_nmi[i] = 1'b0;
    end
    a_ticks = 0; a_hs_low = 0; a_prev_hs = 1'b1;
    b_lines = 0; b_act = 0; b_vs = 0;
  endtask

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      logic set;
      int frame;
      set = 1'b0;
      frame = len_of(i) * LINES;
      if (en) begin
        t[i]++;
        if (t[i] % len_of(i) == 0) m_bank[i] = gfx;
        if (t[i] % frame == 0) m_flip[i] = flip_in;
        if (t[i] % frame == len_of(i) * 248) set = 1'b1;
      end
      if (set) m_nmi[i] = 1'b1;
      else if (ack) m_nmi[i] = 1'b0;
    end
  endtask

  task automatic measure();
    a_ticks++;
    if (!bus_a.O_HSYNCn) a_hs_low++;
    if (a_prev_hs && !bus_a.O_HSYNCn) check("a_hsync_fall_h", 34'(bus_a.O_H_CNT), 34'h140);
    a_prev_hs = bus_a.O_HSYNCn;
    if (bus_a.O_H_CNT == 10'h100) begin
      check("a_line_period", 34'(a_ticks), 34'd768);
      check("a_hsync_width", 34'(a_hs_low), 34'd64);
      a_ticks = 0;
      a_hs_low = 0;
    end
    if (bus_b.O_H_CNT == 10'h3C0) begin
      b_lines++;
      if (!bus_b.O_VBLK) b_act++;
      if (!bus_b.O_VSYNCn) b_vs++;
      if (bus_b.O_V_CNT == 8'hF8 && bus_b.O_VSYNCn) begin
        check("b_lines_per_frame", 34'(b_lines), 34'd264);
        check("b_active_lines", 34'(b_act), 34'd224);
        check("b_vsync_lines", 34'(b_vs), 34'd8);
        check("b_flip_latched", 34'(bus_b.O_FLIP), 34'(flip_in));
        b_lines = 0; b_act = 0; b_vs = 0;
      end
    end
  endtask

  task automatic step(input logic e, input logic a);
    @(negedge clk);
    en  = e;
    ack = a;
    gfx = 1'($urandom_range(1));
    @(posedge clk);
    model_tick();
    #1;
    check("a_state", obs_a, model_vec(0));
    check("b_state", obs_b, model_vec(1));
    if (e) measure();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    model_reset();
    #1;
    check("rst_a", obs_a, RST_A);
    check("rst_b", obs_b, model_vec(1));
    repeat (5) begin
      @(posedge clk);
      #1;
      check("rst_hold_a", obs_a, RST_A);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) step(1'b0, 1'b0);
  endtask

  initial begin
    int held_h;
    logic e, a, collide, ack_clear;
    rst = 1'b1; en = 1'b0; flip_in = 1'b0; gfx = 1'b0; ack = 1'b0;
    model_reset();
    do_reset();

    // Run into the line, then reset mid-line.
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0);
    do_reset();

    // Half-rate enable: two full lines of A.
    for (int k = 0; k < 2 * 2 * LEN_A + 40; k++) step(1'(k % 2), 1'b0);

    // Freeze mid-line, then resume from the same count.
    held_h = model_h(0);
    repeat (100) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("resume_h", 34'(bus_a.O_H_CNT), 34'(held_h + 1));

    // Randomized enable across two frames of B with flip toggles and NMI acks.
    for (int k = 0; k < 38000; k++) begin
      int hb, vb;
      e = ($urandom_range(9) != 0);
      a = 1'b0;
      collide = 1'b0;
      ack_clear = 1'b0;
      hb = model_h(1);
      vb = model_v(1);
      if (e && hb == 'h3FF && vb == 'h1EF && t[1] / (LEN_B * LINES) == 1) begin
        a = 1'b1;
        collide = 1'b1;
      end
      if (e && hb == 'h3C0 && vb == 'h1F3) begin
        a = 1'b1;
        ack_clear = 1'b1;
      end
      if (e && hb == 'h3C0 && vb == 'h150) flip_in = ~flip_in;
      step(e, a);
      if (collide) check("nmi_set_wins", 34'(bus_b.O_NMI_REQ), 34'd1);
      if (ack_clear) check("nmi_ack_clear", 34'(bus_b.O_NMI_REQ), 34'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
